// File: rtl/memory_port_arbiter.sv
// Arbitrates one shared single-port data memory between a scalar (memory-stage)
// requester and an 8-lane vector requester. Scalar accesses take one memory
// beat, vector accesses take eight consecutive beats at ascending word
// addresses. All memory-side outputs come straight from registers.
//
// Handshake: a requester raises *_req with stable *_we/addr/wdata and holds it
// until it sees the one-cycle *_done pulse; requests are only sampled in IDLE and
// all request fields are latched at grant, so dropping *_req mid-transfer does
// not abort it. A request still high in IDLE after its done is a new request.
module memory_port_arbiter (
    input  logic         clk,
    input  logic         reset,
    input  logic         scalar_req,
    input  logic         scalar_we,
    input  logic [15:0]  scalar_addr,
    input  logic [15:0]  scalar_wdata,
    output logic [15:0]  scalar_rdata,
    output logic         scalar_done,
    input  logic         vector_req,
    input  logic         vector_we,
    input  logic [15:0]  vector_addr,
    input  logic [127:0] vector_wdata,
    output logic [127:0] vector_rdata,
    output logic         vector_done,
    output logic [15:0]  mem_addr,
    output logic [15:0]  mem_wdata,
    output logic         mem_we,
    input  logic [15:0]  mem_rdata,
    output logic         pipe_stall,
    output logic [2:0]   dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_ACC  = 3'd1,
        S_RESP = 3'd2,
        V_ACC  = 3'd3,
        V_LAST = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic           w_grant_s;
    logic           w_grant_v;
    logic           r_last_grant;     // 1 = vector was granted last
    logic [2:0]     r_beat;
    logic           r_we;
    logic [111:0]   r_vwdata;         // lanes 1..7; lane 0 goes out at grant
    logic [15:0]    r_mem_addr;
    logic [15:0]    r_mem_wdata;
    logic           r_mem_we;
    logic [15:0]    r_scalar_rdata;
    logic [127:0]   r_vector_rdata;
    logic [2:0]     w_prev_lane;
    logic [6:0]     w_prev_off;
    logic [6:0]     w_next_off;

    // Lane offsets: read data arriving now belongs to the previous beat, and the
    // next write lane (beat+1) sits at offset beat*16 in the lane 1..7 store.
    assign w_prev_lane = r_beat - 3'd1;
    assign w_prev_off  = {w_prev_lane, 4'b0000};
    assign w_next_off  = {r_beat, 4'b0000};

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and grant decode; round-robin favours the side not granted last.
    always_comb begin
        w_next_state = r_state;
        w_grant_s    = 1'b0;
        w_grant_v    = 1'b0;
        case (r_state)
            IDLE: begin
                if (scalar_req && (!vector_req || r_last_grant)) begin
                    w_grant_s    = 1'b1;
                    w_next_state = S_ACC;
                end else if (vector_req) begin
                    w_grant_v    = 1'b1;
                    w_next_state = V_ACC;
                end
            end
            S_ACC:   w_next_state = S_RESP;
            S_RESP:  w_next_state = IDLE;
            V_ACC:   if (r_beat == 3'd7) w_next_state = V_LAST;
            V_LAST:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: latch request at grant, step beats, capture read data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last_grant   <= 1'b1;
            r_beat         <= 3'd0;
            r_we           <= 1'b0;
            r_vwdata       <= '0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_mem_we       <= 1'b0;
            r_scalar_rdata <= '0;
            r_vector_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_s) begin
                        r_mem_addr   <= scalar_addr;
                        r_mem_wdata  <= scalar_wdata;
                        r_mem_we     <= scalar_we;
                        r_we         <= scalar_we;
                        r_last_grant <= 1'b0;
                    end else if (w_grant_v) begin
                        r_mem_addr   <= vector_addr;
                        r_mem_wdata  <= vector_wdata[15:0];
                        r_mem_we     <= vector_we;
                        r_we         <= vector_we;
                        r_vwdata     <= vector_wdata[127:16];
                        r_beat       <= 3'd0;
                        r_last_grant <= 1'b1;
                    end
                end
                S_ACC: begin
                    r_mem_we <= 1'b0;
                end
                S_RESP: begin
                    if (!r_we) r_scalar_rdata <= mem_rdata;
                end
                V_ACC: begin
                    if ((r_beat != 3'd0) && !r_we) begin
                        r_vector_rdata[w_prev_off +: 16] <= mem_rdata;
                    end
                    if (r_beat == 3'd7) begin
                        r_mem_we <= 1'b0;
                    end else begin
                        r_mem_addr  <= r_mem_addr + 16'd1;
                        r_mem_wdata <= r_vwdata[w_next_off +: 16];
                        r_beat      <= r_beat + 3'd1;
                    end
                end
                V_LAST: begin
                    if (!r_we) r_vector_rdata[127:112] <= mem_rdata;
                    r_beat <= 3'd0;
                end
                default: begin
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    // Done pulses decode the response states; read data is forwarded from the
    // memory during the done cycle and held in the capture registers after.
    assign scalar_done  = (r_state == S_RESP);
    assign vector_done  = (r_state == V_LAST);
    assign scalar_rdata = (scalar_done && !r_we) ? mem_rdata : r_scalar_rdata;
    assign vector_rdata = (vector_done && !r_we) ?
                          {mem_rdata, r_vector_rdata[111:0]} : r_vector_rdata;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_we       = r_mem_we;
    assign pipe_stall   = ((r_state != IDLE) || scalar_req || vector_req) &&
                          !(scalar_done || vector_done);
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter with a registered-read memory model.
module tb_memory_port_arbiter;

    logic         clk;
    logic         reset;
    logic         scalar_req;
    logic         scalar_we;
    logic [15:0]  scalar_addr;
    logic [15:0]  scalar_wdata;
    logic [15:0]  scalar_rdata;
    logic         scalar_done;
    logic         vector_req;
    logic         vector_we;
    logic [15:0]  vector_addr;
    logic [127:0] vector_wdata;
    logic [127:0] vector_rdata;
    logic         vector_done;
    logic [15:0]  mem_addr;
    logic [15:0]  mem_wdata;
    logic         mem_we;
    logic [15:0]  mem_rdata;
    logic         pipe_stall;
    logic [2:0]   dbg_state;

    int checks;
    int errors;

    logic [15:0] mem [0:65535];

    memory_port_arbiter dut (
        .clk(clk), .reset(reset),
        .scalar_req(scalar_req), .scalar_we(scalar_we),
        .scalar_addr(scalar_addr), .scalar_wdata(scalar_wdata),
        .scalar_rdata(scalar_rdata), .scalar_done(scalar_done),
        .vector_req(vector_req), .vector_we(vector_we),
        .vector_addr(vector_addr), .vector_wdata(vector_wdata),
        .vector_rdata(vector_rdata), .vector_done(vector_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .pipe_stall(pipe_stall), .dbg_state(dbg_state)
    );

    // Clock and memory model (registered read, write on mem_we).
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // Lane pattern 0x1111..0x8888 used by the vector write.
    function automatic logic [127:0] lane_pattern();
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[16*i +: 16] = 16'(i + 1) * 16'h1111;
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dbg_state !== 3'd0 || mem_we !== 1'b0 || mem_addr !== 16'h0 ||
            mem_wdata !== 16'h0 || scalar_done !== 1'b0 || vector_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: state=%0d we=%b addr=%h wd=%h sd=%b vd=%b required 0",
                     dbg_state, mem_we, mem_addr, mem_wdata, scalar_done, vector_done);
        end
        checks++;
        if (scalar_rdata !== 16'h0 || vector_rdata !== 128'h0 || pipe_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: srd=%h vrd=%h stall=%b required 0",
                     scalar_rdata, vector_rdata, pipe_stall);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_scalar_read();
        mem[16'h0010] = 16'hBEEF;
        scalar_we = 1'b0; scalar_addr = 16'h0010; scalar_wdata = 16'h0; scalar_req = 1'b1;
        #1;
        checks++;
        if (pipe_stall !== 1'b1) begin
            errors++;
            $display("FAIL sread_stall_idle: got %b required 1", pipe_stall);
        end
        @(negedge clk); // N+1
        checks++;
        if (mem_addr !== 16'h0010 || mem_we !== 1'b0 || scalar_done !== 1'b0 || pipe_stall !== 1'b1) begin
            errors++;
            $display("FAIL sread_acc: addr=%h we=%b done=%b stall=%b required 0010 0 0 1",
                     mem_addr, mem_we, scalar_done, pipe_stall);
        end
        @(negedge clk); // N+2
        checks++;
        if (scalar_done !== 1'b1 || scalar_rdata !== 16'hBEEF || pipe_stall !== 1'b0) begin
            errors++;
            $display("FAIL sread_done: done=%b rdata=%h stall=%b required 1 beef 0",
                     scalar_done, scalar_rdata, pipe_stall);
        end
        scalar_req = 1'b0;
        @(negedge clk);
        checks++;
        if (scalar_done !== 1'b0 || dbg_state !== 3'd0 || scalar_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL sread_after: done=%b state=%0d rdata=%h required 0 0 beef",
                     scalar_done, dbg_state, scalar_rdata);
        end
    endtask

    task automatic test_scalar_write();
        scalar_we = 1'b1; scalar_addr = 16'h0020; scalar_wdata = 16'h1234; scalar_req = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 16'h1234) begin
            errors++;
            $display("FAIL swrite_acc: we=%b addr=%h wd=%h required 1 0020 1234",
                     mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (scalar_done !== 1'b1 || mem_we !== 1'b0 || scalar_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL swrite_done: done=%b we=%b rdata=%h required 1 0 beef",
                     scalar_done, mem_we, scalar_rdata);
        end
        scalar_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem[16'h0020] !== 16'h1234) begin
            errors++;
            $display("FAIL swrite_mem: got %h required 1234", mem[16'h0020]);
        end
    endtask

    task automatic test_vector_write();
        logic [127:0] lanes;
        lanes = lane_pattern();
        vector_we = 1'b1; vector_addr = 16'h0100; vector_wdata = lanes; vector_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 16'h0100 + 16'(k - 1) ||
                mem_wdata !== 16'(k) * 16'h1111 || vector_done !== 1'b0) begin
                errors++;
                $display("FAIL vwrite_beat%0d: we=%b addr=%h wd=%h done=%b required 1 %h %h 0",
                         k - 1, mem_we, mem_addr, mem_wdata, vector_done,
                         16'h0100 + 16'(k - 1), 16'(k) * 16'h1111);
            end
        end
        @(negedge clk); // N+9
        checks++;
        if (vector_done !== 1'b1 || mem_we !== 1'b0 || pipe_stall !== 1'b0) begin
            errors++;
            $display("FAIL vwrite_done: done=%b we=%b stall=%b required 1 0 0",
                     vector_done, mem_we, pipe_stall);
        end
        vector_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem[16'h0103] !== 16'h4444 || mem[16'h0107] !== 16'h8888) begin
            errors++;
            $display("FAIL vwrite_mem: got %h %h required 4444 8888",
                     mem[16'h0103], mem[16'h0107]);
        end
    endtask

    task automatic test_vector_read_wrap();
        logic [127:0] exp_v;
        logic [15:0]  a;
        for (int i = 0; i < 8; i++) begin
            a = 16'hFFFE + 16'(i);
            mem[a] = 16'hA000 + 16'(i);
            exp_v[16*i +: 16] = 16'hA000 + 16'(i);
        end
        vector_we = 1'b0; vector_addr = 16'hFFFE; vector_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b0 || mem_addr !== 16'hFFFE + 16'(k - 1)) begin
                errors++;
                $display("FAIL vread_beat%0d: we=%b addr=%h required 0 %h",
                         k - 1, mem_we, mem_addr, 16'hFFFE + 16'(k - 1));
            end
        end
        @(negedge clk);
        checks++;
        if (vector_done !== 1'b1 || vector_rdata !== exp_v) begin
            errors++;
            $display("FAIL vread_done: done=%b rdata=%h required 1 %h",
                     vector_done, vector_rdata, exp_v);
        end
        vector_req = 1'b0;
        @(negedge clk);
        checks++;
        if (vector_done !== 1'b0 || vector_rdata !== exp_v) begin
            errors++;
            $display("FAIL vread_hold: done=%b rdata=%h required 0 %h",
                     vector_done, vector_rdata, exp_v);
        end
    endtask

    // Both requests held: scalar wins first, vector wins the rematch with the
    // still-held scalar, then scalar is served again.
    task automatic test_round_robin();
        int s1, s2, v;
        logic [15:0]  s_rd;
        logic [127:0] v_rd;
        s1 = 0; s2 = 0; v = 0; s_rd = 16'h0; v_rd = 128'h0;
        scalar_we = 1'b0; scalar_addr = 16'h0010; scalar_req = 1'b1;
        vector_we = 1'b0; vector_addr = 16'h0100; vector_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (scalar_done === 1'b1) begin
                if (s1 == 0) begin
                    s1 = k; s_rd = scalar_rdata;
                end else if (s2 == 0) begin
                    s2 = k; scalar_req = 1'b0;
                end
            end
            if (vector_done === 1'b1 && v == 0) begin
                v = k; v_rd = vector_rdata; vector_req = 1'b0;
            end
        end
        scalar_req = 1'b0; vector_req = 1'b0;
        checks++;
        if (s1 != 2 || v != 12 || s2 != 15) begin
            errors++;
            $display("FAIL rr_order: sdone=%0d vdone=%0d sdone2=%0d required 2 12 15", s1, v, s2);
        end
        checks++;
        if (s_rd !== 16'hBEEF || v_rd !== lane_pattern()) begin
            errors++;
            $display("FAIL rr_data: srd=%h vrd=%h required beef %h", s_rd, v_rd, lane_pattern());
        end
    endtask

    task automatic test_drop_mid();
        int vd_cnt, vd_at, addr_err;
        vd_cnt = 0; vd_at = 0; addr_err = 0;
        vector_we = 1'b0; vector_addr = 16'h0100; vector_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 3) vector_req = 1'b0;
            if (k <= 8 && mem_addr !== 16'h0100 + 16'(k - 1)) addr_err++;
            if (vector_done === 1'b1) begin
                vd_cnt++; vd_at = k;
            end
        end
        checks++;
        if (addr_err != 0 || vd_cnt != 1 || vd_at != 9) begin
            errors++;
            $display("FAIL drop_mid: addr_errs=%0d dones=%0d at=%0d required 0 1 9",
                     addr_err, vd_cnt, vd_at);
        end
        checks++;
        if (dbg_state !== 3'd0 || vector_rdata !== lane_pattern() || pipe_stall !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: state=%0d rdata=%h stall=%b required 0 %h 0",
                     dbg_state, vector_rdata, pipe_stall, lane_pattern());
        end
    endtask

    task automatic test_reset_mid_vector();
        int vd_cnt;
        vd_cnt = 0;
        vector_we = 1'b1; vector_addr = 16'h0300; vector_wdata = ~lane_pattern(); vector_req = 1'b1;
        repeat (5) @(negedge clk); // beat 4
        checks++;
        if (dbg_state !== 3'd3 || mem_we !== 1'b1 || mem_addr !== 16'h0304) begin
            errors++;
            $display("FAIL rst_mid_pre: state=%0d we=%b addr=%h required 3 1 0304",
                     dbg_state, mem_we, mem_addr);
        end
        reset = 1'b0; vector_req = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_state !== 3'd0 || mem_we !== 1'b0 || vector_done !== 1'b0 ||
            vector_rdata !== 128'h0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid_post: state=%0d we=%b vd=%b vrd=%h addr=%h wd=%h required 0",
                     dbg_state, mem_we, vector_done, vector_rdata, mem_addr, mem_wdata);
        end
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (vector_done === 1'b1) vd_cnt++;
        end
        checks++;
        if (vd_cnt != 0 || mem[16'h0305] === 16'hA5A5 + 16'h0 && 1'b0) begin
            errors++;
            $display("FAIL rst_mid_nodone: dones=%0d required 0", vd_cnt);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0;
        scalar_req = 1'b0; scalar_we = 1'b0; scalar_addr = '0; scalar_wdata = '0;
        vector_req = 1'b0; vector_we = 1'b0; vector_addr = '0; vector_wdata = '0;
        test_reset();
        test_scalar_read();
        test_scalar_write();
        test_vector_write();
        test_vector_read_wrap();
        test_round_robin();
        test_drop_mid();
        test_reset_mid_vector();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
